mos_stream_driver: RTL

//  Initiator for the MOS matrix-multiply serial interface. Holds one weight and one input

---
 rtl/mos_stream_driver.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/mos_stream_driver.sv
`timescale 1ns/1ps
// Host-side initiator for the MOS matrix-multiply serial interface.
// Holds a weight and an input matrix (4x4 or 8x8, 16b signed), streams both
// to MOS on start, then captures the diagonal-sum results into a read buffer.
module mos_stream_driver #(
  parameter int unsigned TIMEOUT = 255  // max WAIT cycles without mos_out_valid (1..255)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cfg_size,
  input  logic        wr_en,
  input  logic        wr_sel,
  input  logic [5:0]  wr_addr,
  input  logic [15:0] wr_data,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        err_timeout,
  output logic        err_len,
  output logic [3:0]  res_count,
  input  logic [3:0]  res_rd_addr,
  output logic [39:0] res_rd_data,
  output logic        mos_matrix_size,
  output logic        mos_in_valid,
  output logic [15:0] mos_in_data,
  input  logic        mos_out_valid,
  input  logic [39:0] mos_out_data
);

  typedef enum logic [2:0] {
    S_IDLE, S_SEND_W, S_SEND_I, S_WAIT, S_RECV, S_DONE
  } state_t;

  localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

  state_t      state_q, state_d;
  logic        size_q;
  logic [5:0]  k_q;
  logic [7:0]  wait_cnt_q;
  logic [3:0]  res_count_q;
  logic        err_timeout_q, err_len_q;
  logic [39:0] res_rd_data_q;

  logic [15:0] weight_mem [64];
  logic [15:0] input_mem  [64];
  logic [39:0] res_mem    [15];

  logic       last_k;
  logic [3:0] res_expected;
  logic       timeout_hit;

  assign last_k       = (k_q == (size_q ? 6'd63 : 6'd15));
  assign res_expected = size_q ? 4'd15 : 4'd7;
  assign timeout_hit  = (wait_cnt_q == TIMEOUT_CNT);

  // State register; an asynchronous reset drops the FSM straight to IDLE.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic: IDLE -> SEND_W -> SEND_I -> WAIT -> RECV -> DONE -> IDLE.
  always_comb begin
    // NOTE: default assignment first so no path leaves state_d unassigned,
    // which would otherwise infer a latch.
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   if (start)          state_d = S_SEND_W;
      S_SEND_W: if (last_k)         state_d = S_SEND_I;
      S_SEND_I: if (last_k)         state_d = S_WAIT;
      S_WAIT: begin
        if (mos_out_valid)          state_d = S_RECV;
        else if (timeout_hit)       state_d = S_DONE;
      end
      S_RECV:   if (!mos_out_valid) state_d = S_DONE;
      S_DONE:                       state_d = S_IDLE;
      default:                      state_d = S_IDLE;
    endcase
  end

  // Outputs decoded from the current state; data forced to zero outside streaming.
  always_comb begin
    busy            = (state_q != S_IDLE);
    done            = (state_q == S_DONE);
    mos_in_valid    = (state_q == S_SEND_W) || (state_q == S_SEND_I);
    mos_in_data     = '0;
    if (state_q == S_SEND_W) mos_in_data = weight_mem[k_q];
    if (state_q == S_SEND_I) mos_in_data = input_mem[k_q];
    mos_matrix_size = mos_in_valid & size_q;
  end

  // Transaction datapath: element index, wait counter, result capture and error flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      size_q        <= 1'b0;
      k_q           <= '0;
      wait_cnt_q    <= '0;
      res_count_q   <= '0;
      err_timeout_q <= 1'b0;
      err_len_q     <= 1'b0;
      // The result buffer is small and observable through the read port,
      // so it is cleared on reset as well as on every accepted start.
      for (int i = 0; i < 15; i++) res_mem[i] <= '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            size_q        <= cfg_size;
            k_q           <= '0;
            res_count_q   <= '0;
            err_timeout_q <= 1'b0;
            err_len_q     <= 1'b0;
            for (int i = 0; i < 15; i++) res_mem[i] <= '0;
          end
        end
        S_SEND_W: k_q <= last_k ? 6'd0 : k_q + 6'd1;
        S_SEND_I: begin
          k_q <= last_k ? 6'd0 : k_q + 6'd1;
          if (last_k) wait_cnt_q <= 8'd1;
        end
        S_WAIT: begin
          if (mos_out_valid) begin
            res_mem[0]  <= mos_out_data;
            res_count_q <= 4'd1;
          end else if (timeout_hit) begin
            err_timeout_q <= 1'b1;
            err_len_q     <= (res_count_q != res_expected);
          end else begin
            wait_cnt_q <= wait_cnt_q + 8'd1;
          end
        end
        S_RECV: begin
          if (mos_out_valid) begin
            // Index 15 does not exist: extra results are dropped, count saturates.
            if (res_count_q != 4'd15) begin
              res_mem[res_count_q] <= mos_out_data;
              res_count_q          <= res_count_q + 4'd1;
            end
          end else begin
            err_len_q <= (res_count_q != res_expected);
          end
        end
        default: ;
      endcase
    end
  end

  // Matrix buffers: local write port, honoured only while idle.
  always_ff @(posedge clk) begin
    // NOTE: plain RAM with no reset; contents survive rst so a transaction
    // can be re-run after an abort without reloading.
    if (wr_en && (state_q == S_IDLE)) begin
      if (wr_sel) input_mem[wr_addr]  <= wr_data;
      else        weight_mem[wr_addr] <= wr_data;
    end
  end

  // Registered result read port, one-cycle latency, valid in any state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                      res_rd_data_q <= '0;
    else if (res_rd_addr < 4'd15) res_rd_data_q <= res_mem[res_rd_addr];
    else                          res_rd_data_q <= '0;
  end

  assign res_rd_data = res_rd_data_q;
  assign res_count   = res_count_q;
  assign err_timeout = err_timeout_q;
  assign err_len     = err_len_q;

endmodule
